// File: rtl/conv_pkg.sv
// Shared constants for the con_v convolution datapath and its window feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

  // Pixel/tap width, equal to the con_v SIZE parameter.
  localparam int CONV_SIZE  = 23;
  // Width of the con_v convolution result.
  localparam int CONV_OUT_W = 2 * CONV_SIZE - 1;
  // Default image geometry.
  localparam int CONV_IMG_W = 28;
  localparam int CONV_IMG_H = 28;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Fixed-length delay line: dout is the sample written DEPTH shifts ago.
// Latency: DEPTH accepted shifts; dout is a combinational read of the oldest entry.
// Backpressure: none internally; contents and pointer hold while shift_en is low.
// Ports: clk, rst (sync, active-high, pointer only), shift_en, din, dout.
module line_fifo
  import conv_pkg::*;
#(
  parameter int SIZE  = CONV_SIZE,
  parameter int DEPTH = CONV_IMG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic signed [SIZE-1:0] din,
  output logic signed [SIZE-1:0] dout
);

  localparam int PW = cnt_w(DEPTH);

  logic signed [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]          ptr;

  // Circular buffer with one pointer: the slot about to be overwritten is
  // exactly the one written DEPTH shifts ago, so it is read before the write.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator for con_v from a raster-scan pixel stream.
// Latency: 1 cycle from accepted pixel to p9 / win_valid.
// Backpressure: pix_ready = !win_valid || win_ready; a held window freezes all state.
// Ports: clk, rst (sync, active-high); pix_in/pix_valid/pix_ready input stream;
//        p1..p9 taps (row-major, p1 oldest) with win_valid/win_ready; frame_done pulse.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int SIZE  = CONV_SIZE,
  parameter int IMG_W = CONV_IMG_W,
  parameter int IMG_H = CONV_IMG_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [SIZE-1:0] pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic signed [SIZE-1:0] p1,
  output logic signed [SIZE-1:0] p2,
  output logic signed [SIZE-1:0] p3,
  output logic signed [SIZE-1:0] p4,
  output logic signed [SIZE-1:0] p5,
  output logic signed [SIZE-1:0] p6,
  output logic signed [SIZE-1:0] p7,
  output logic signed [SIZE-1:0] p8,
  output logic signed [SIZE-1:0] p9,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic                   frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic signed [SIZE-1:0] win [9];
  logic signed [SIZE-1:0] line_a_dat;
  logic signed [SIZE-1:0] line_b_dat;
  logic                   accept;
  logic                   col_last;
  logic                   row_last;
  logic                   qualify;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == RW'(IMG_H - 1));
  // Judged on pre-increment position: only pixels with two rows and two
  // columns of history behind them complete a neighbourhood.
  assign qualify   = (row >= RW'(2)) && (col >= CW'(2));

  // Line A delays the live stream by one row; line B delays line A by another.
  line_fifo #(.SIZE(SIZE), .DEPTH(IMG_W)) u_line_a (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (pix_in),
    .dout     (line_a_dat)
  );

  line_fifo #(.SIZE(SIZE), .DEPTH(IMG_W)) u_line_b (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (line_a_dat),
    .dout     (line_b_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window register file; each row shifts left and takes a new right column
  // from (line B, line A, live pixel).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= line_b_dat;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= line_a_dat;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (pix_ready) begin
        win_valid <= accept && qualify;
      end
    end
  end

  assign p1 = win[0];
  assign p2 = win[1];
  assign p3 = win[2];
  assign p4 = win[3];
  assign p5 = win[4];
  assign p6 = win[5];
  assign p7 = win[6];
  assign p8 = win[7];
  assign p9 = win[8];

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Upstream feeder for the `con_v` 3x3 convolution stage. It accepts a raster-scan pixel stream (row-major, one signed SIZE-bit pixel per accepted beat) and stores the two previous image rows in line buffers. For each pixel that completes a full 3x3 neighbourhood it presents the nine taps `p1..p9`, ordered to match the `con_v` kernel ports `w1..w9`. It also drives `con_v`'s `conv_en` through a valid/ready handshake.

## Interface
- `SIZE`, 23, pixel/tap width (signed), equal to the `con_v` SIZE
- `IMG_W`, 28, image width in pixels (>= 3)
- `IMG_H`, 28, image height in rows (>= 3)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pix_in`  in  SIZE  signed input pixel
- `pix_valid`  in  1  `pix_in` is valid this cycle
- `pix_ready`  out  1  block can accept a pixel; a pixel is accepted on a cycle where `pix_valid && pix_ready`
- `p1`..`p9`  out  SIZE each  window taps, row-major: `p1` is top-left (oldest row, oldest column), `p9` is the newest pixel
- `win_valid`  out  1  `p1..p9` hold a complete window; wired to `con_v.conv_en`
- `win_ready`  in  1  downstream consumes the window this cycle
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame (row IMG_H-1, column IMG_W-1) is accepted

## Operation
- Counters: `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1. Both advance only on an accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - At the last pixel of the frame, both wrap to 0, so the next accepted pixel starts a new frame.
- Line buffers: two IMG_W-deep delay lines, chained. Line A holds the previous row and line B holds the row before that. On every accepted pixel both shift by one entry.
- Window shift: on an accepted pixel each window row shifts left one column (`p1<=p2<=p3`, `p4<=p5<=p6`, `p7<=p8<=p9`). The new right-hand column loads as:
  - `p3` from line B output
  - `p6` from line A output
  - `p9` from `pix_in`
- Window validity: the accepted pixel produces a window iff `row>=2 && col>=2`, with `row` and `col` taken before the increment. That gives (IMG_W-2)*(IMG_H-2) windows per frame. Pixels in columns 0..1 or rows 0..1 only fill the buffers.
- Handshake: `pix_ready = !win_valid || win_ready`.
  - While a window is held and not consumed, no pixel is accepted, so `p1..p9` and the line buffers stay frozen.
  - `win_valid` updates only on a cycle where `pix_ready` is high:
    - it sets if that cycle accepts a pixel with `row>=2 && col>=2`;
    - otherwise it clears.
- Stale data: line-buffer contents are never cleared between frames. Stale data from the previous frame is never visible, because any valid window of a frame uses only that frame's rows 0..2+ and columns 0..2+.
- Arithmetic: none. Pixels pass through bit-exact with sign preserved.

## Timing
- Latency: a pixel accepted at edge k appears in `p9`, with `win_valid` (if qualifying), after edge k. That is 1 cycle.
- Throughput: one pixel per cycle while `win_ready` is held high.
- `frame_done` is high for exactly the cycle after edge k, where k accepts the frame's last pixel. This is independent of `win_ready`.
- Simultaneous events on one cycle: `win_valid && win_ready && pix_valid` consumes the current window and accepts the next pixel. No bubble is inserted.
- Reset values:
  - `win_valid=0`, `frame_done=0`, `pix_ready=1`
  - `p1..p9=0`
  - `row=col=0`
  - line-buffer contents are don't-care
- Reset mid-frame: the partial frame is abandoned, and the first pixel accepted after reset is row 0, column 0.

## Structure
- Shared package `conv_pkg`:
  - the `SIZE` default (23);
  - the `con_v` output width constant (2*SIZE-1 = 45);
  - the `IMG_W`/`IMG_H` defaults.
- Sub-module `line_fifo`:
  - a parameterised (SIZE, DEPTH) delay line with a shift enable;
  - circular RAM with a single pointer, or a register chain;
  - instantiated twice, for line A and line B.
- Top level holds the counters, the window register file and the handshake logic.

## Test plan
- **Basic window:** IMG_W=IMG_H=4, pixels 1..16 streamed with `win_ready=1`. First `win_valid` comes after pixel 11, with `p1..p9`=1,2,3,5,6,7,9,10,11. Next window is 2,3,4,6,7,8,10,11,12. There are exactly 4 windows, and the last is 6,7,8,10,11,12,14,15,16.
- **Row-start gating:** same stream. No `win_valid` after pixels 13 or 14. The window after pixel 15 is 5,6,7,9,10,11,13,14,15. `frame_done` pulses once, after pixel 16.
- **Backpressure:** `win_ready=0` for 5 cycles after the first window. Check that `pix_ready=0`, that `p1..p9` stay 1,2,3,5,6,7,9,10,11, and that no pixel is lost. On release, the window sequence is identical to the basic-window test.
- **Signed data:** pixels of -1 (all ones) and -(2^22). Check the taps are bit-exact and no sign is lost.
- **Back-to-back frames:** pixels 101..116 directly after frame 1. The first window is 101,102,103,105,106,107,109,110,111, with no frame-1 data visible.
- **Mid-frame reset:** assert `rst` after pixel 7. Check `win_valid=0` and `pix_ready=1`. A full 1..16 frame after reset then reproduces the basic-window results.
